// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RISC-V integer datapath widths and types
package rv_pkg;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef logic [XLEN-1:0] xlen_t;
    typedef logic [AW-1:0]   regaddr_t;
endpackage

// File: rtl/rv_regfile_2r1w_if.sv
// rtl/rv_regfile_2r1w_if.sv - decode-side bundle for the 2-read/1-write register file
interface rv_regfile_2r1w_if;
    import rv_pkg::*;

    xlen_t    readData1;
    xlen_t    readData2;
    xlen_t    writeData;
    logic     RegWrite;
    regaddr_t readReg1;
    regaddr_t readReg2;
    regaddr_t writeReg;

    modport master (
        input  readData1, readData2,
        output writeData, RegWrite, readReg1, readReg2, writeReg
    );

    modport slave (
        output readData1, readData2,
        input  writeData, RegWrite, readReg1, readReg2, writeReg
    );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - combinational read mux with x0 forcing and optional write bypass
module rf_read_port
    import rv_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  regaddr_t addr,
    input  xlen_t    regs [1:NREGS-1],
    input  logic     wrEn,
    input  regaddr_t wrAddr,
    input  xlen_t    wrData,
    output xlen_t    data
);
    // x0 is checked first so a bypassed write to x0 can never leak through.
    always_comb begin
        data = '0;
        if (addr != '0) begin
            if (BYPASS && wrEn && (addr == wrAddr)) begin
                data = wrData;
            end else begin
                data = regs[addr];
            end
        end
    end
endmodule

// File: rtl/rv_regfile_2r1w.sv
// rtl/rv_regfile_2r1w.sv - 32 x 64-bit RISC-V integer register file, two async reads, one sync write
module rv_regfile_2r1w
    import rv_pkg::*;
#(
    parameter bit WR_BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    rv_regfile_2r1w_if.slave   rf
);
    xlen_t regs [1:NREGS-1];
    logic  wrLive;

    // Per-entry address compare: an unknown writeReg matches no entry, so it cannot corrupt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.RegWrite) begin
            for (int i = 1; i < NREGS; i++) begin
                if (rf.writeReg == regaddr_t'(i)) begin
                    regs[i] <= rf.writeData;
                end
            end
        end
    end

    assign wrLive = rf.RegWrite & rst_n;

    rf_read_port #(.BYPASS(WR_BYPASS)) u_port1 (
        .addr   (rf.readReg1),
        .regs   (regs),
        .wrEn   (wrLive),
        .wrAddr (rf.writeReg),
        .wrData (rf.writeData),
        .data   (rf.readData1)
    );

    rf_read_port #(.BYPASS(WR_BYPASS)) u_port2 (
        .addr   (rf.readReg2),
        .regs   (regs),
        .wrEn   (wrLive),
        .wrAddr (rf.writeReg),
        .wrData (rf.writeData),
        .data   (rf.readData2)
    );
endmodule

// File: tb/tb_rv_regfile_2r1w.sv
// tb/tb_rv_regfile_2r1w.sv - self-checking bench for rv_regfile_2r1w
module tb_rv_regfile_2r1w;
    localparam bit BYP = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic cmpOn = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [63:0] model [32];

    rv_regfile_2r1w_if rfIf ();

    rv_regfile_2r1w #(.WR_BYPASS(BYP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rfIf.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (BYP && rfIf.RegWrite && rst_n && (a == rfIf.writeReg)) return rfIf.writeData;
        return model[a];
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end

    always @(posedge clk) begin
        if (rst_n && rfIf.RegWrite && rfIf.writeReg != 5'd0)
            model[rfIf.writeReg] = rfIf.writeData;
    end

    always @(negedge clk) begin
        if (cmpOn) begin
            chk("model_rd1", rfIf.readData1, expRead(rfIf.readReg1));
            chk("model_rd2", rfIf.readData2, expRead(rfIf.readReg2));
        end
    end

    task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic en);
        rfIf.RegWrite  = en;
        rfIf.writeReg  = a;
        rfIf.writeData = d;
        @(posedge clk);
        #2;
        rfIf.RegWrite = 1'b0;
    endtask

    initial begin
        logic [4:0] ra;
        rfIf.RegWrite  = 1'b0;
        rfIf.writeReg  = 5'd0;
        rfIf.writeData = 64'd0;
        rfIf.readReg1  = 5'd0;
        rfIf.readReg2  = 5'd0;

        // 1: reset pulse, then read x3/x1
        #7 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        rfIf.readReg1 = 5'd3;
        rfIf.readReg2 = 5'd1;
        #1;
        chk("reset_rd1", rfIf.readData1, 64'd0);
        chk("reset_rd2", rfIf.readData2, 64'd0);
        cmpOn = 1'b1;

        // 2: write x3
        wr(5'd3, 64'hDEAD_BEEF_0000_0005, 1'b1);
        #1;
        chk("wr_x3", rfIf.readData1, 64'hDEAD_BEEF_0000_0005);

        // 3: write to x0 discarded
        wr(5'd0, 64'd5, 1'b1);
        rfIf.readReg1 = 5'd0;
        rfIf.readReg2 = 5'd0;
        #1;
        chk("x0_rd1", rfIf.readData1, 64'd0);
        chk("x0_rd2", rfIf.readData2, 64'd0);

        // 4: RegWrite=0 leaves x31 alone
        wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        rfIf.readReg2 = 5'd31;
        #1;
        chk("nowr_x31", rfIf.readData2, 64'd0);

        // 5: same-cycle read/write of x7
        wr(5'd7, 64'd1, 1'b1);
        rfIf.RegWrite  = 1'b1;
        rfIf.writeReg  = 5'd7;
        rfIf.writeData = 64'd9;
        rfIf.readReg1  = 5'd7;
        #1;
        chk("byp_before", rfIf.readData1, BYP ? 64'd9 : 64'd1);
        @(posedge clk);
        #2;
        rfIf.RegWrite = 1'b0;
        #1;
        chk("byp_after", rfIf.readData1, 64'd9);

        // 6: fill x1..x31 with index, sweep both ports
        for (int i = 1; i < 32; i++) wr(5'(i), 64'(i), 1'b1);
        for (int i = 0; i < 32; i++) begin
            rfIf.readReg1 = 5'(i);
            rfIf.readReg2 = 5'(31 - i);
            #1;
            chk("sweep_rd1", rfIf.readData1, 64'(i));
            chk("sweep_rd2", rfIf.readData2, 64'(31 - i));
        end
        @(posedge clk);
        #2;
        rfIf.readReg1 = 5'd5;
        rfIf.readReg2 = 5'd17;
        #1;
        chk("pre_rst_x5", rfIf.readData1, 64'd5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_x5", rfIf.readData1, 64'd0);
        chk("async_rst_x17", rfIf.readData2, 64'd0);
        rfIf.readReg1 = 5'd31;
        #1;
        chk("async_rst_x31", rfIf.readData1, 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // reset wins over a concurrent write
        @(posedge clk);
        #2;
        rfIf.RegWrite  = 1'b1;
        rfIf.writeReg  = 5'd9;
        rfIf.writeData = 64'h1234;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rfIf.RegWrite = 1'b0;
        rfIf.readReg1 = 5'd9;
        #1;
        chk("rst_wins_x9", rfIf.readData1, 64'd0);

        // randomized traffic checked by the model on every negedge
        for (int n = 0; n < 500; n++) begin
            @(posedge clk);
            #2;
            rst_n          = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            rfIf.RegWrite  = 1'($urandom_range(0, 1));
            rfIf.writeReg  = 5'($urandom_range(0, 31));
            rfIf.writeData = {$urandom, $urandom};
            ra = 5'($urandom_range(0, 31));
            rfIf.readReg1  = ($urandom_range(0, 3) == 0) ? rfIf.writeReg : ra;
            rfIf.readReg2  = 5'($urandom_range(0, 31));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rfIf.RegWrite = 1'b0;
        @(negedge clk);
        #1;
        cmpOn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
